// File: rtl/watch_timekeeper_pkg.sv
// Shared types for the watch time-of-day core: mode encoding, BCD digit/pair types, helpers.
// Optional alarm feature is selected elsewhere with the ALARM_EN macro.
package watch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned MODE_W  = 3;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd_pair_t;

    typedef enum logic [MODE_W-1:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HR  = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    localparam bcd_pair_t BCD_RESET = 8'h00;

    // Decimal 0..99 to a two-digit BCD pair (used for wrap limits).
    function automatic bcd_pair_t to_bcd(input int unsigned v);
        bcd_pair_t r;
        r.tens  = DIGIT_W'((v / 10) % 10);
        r.units = DIGIT_W'(v % 10);
        return r;
    endfunction

    // BCD +1 with units 9->0 carrying into tens; no binary value ever exposed.
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
        bcd_pair_t r;
        if (v.units == 4'd9) begin
            r.tens  = v.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.tens  = v.tens;
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/watch_timekeeper_if.sv
// Handshake/display bundle between the watch core and its neighbours.
// Alarm signals exist only when ALARM_EN is defined.
interface watch_timekeeper_if;
    import watch_pkg::*;

    logic      clk_1hz;
    logic      btn_mode;
    logic      btn_inc;
    bcd_pair_t hour_bcd;
    bcd_pair_t min_bcd;
    bcd_pair_t sec_bcd;
    mode_t     mode;
    logic      tick_out;
`ifdef ALARM_EN
    logic      alarm_on;
    logic      alarm_ring;
    bcd_pair_t al_hour_bcd;
    bcd_pair_t al_min_bcd;
`endif

    modport master (
        output clk_1hz, btn_mode, btn_inc,
`ifdef ALARM_EN
        output alarm_on,
        input  alarm_ring, al_hour_bcd, al_min_bcd,
`endif
        input  hour_bcd, min_bcd, sec_bcd, mode, tick_out
    );

    modport slave (
        input  clk_1hz, btn_mode, btn_inc,
`ifdef ALARM_EN
        input  alarm_on,
        output alarm_ring, al_hour_bcd, al_min_bcd,
`endif
        output hour_bcd, min_bcd, sec_bcd, mode, tick_out
    );

endinterface

// File: rtl/watch_timekeeper_bcd_mod_counter.sv
// Two-digit BCD register wrapping MAX->00, with synchronous clear and a wrap carry.
module bcd_mod_counter
    import watch_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      inc,
    input  logic      clr,
    output bcd_pair_t value,
    output logic      carry
);

    localparam bcd_pair_t MAX_BCD = to_bcd(MAX);

    logic at_max;

    assign at_max = (value == MAX_BCD);
    assign carry  = inc & at_max;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= BCD_RESET;
        end else if (inc) begin
            value <= at_max ? BCD_RESET : bcd_inc(value);
        end
    end

endmodule

// File: rtl/watch_timekeeper.sv
// Watch time-of-day core: 1 Hz edge detect, set-mode FSM, BCD hh:mm:ss chain.
// Define ALARM_EN to add the alarm fields, alarm set states and alarm_ring.
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned MIN_MAX  = 59
) (
    input logic                clk_27Mhz,
    input logic                reset,
    watch_timekeeper_if.slave  bus
);

    logic      clk_1hz_q;
    logic      tick;
    mode_t     state;
    logic      tick_out;
    logic      sec_inc, min_inc, hour_inc, sec_clr;
    logic      sec_carry, min_carry;
    bcd_pair_t sec_val, min_val, hour_val;

    assign tick = bus.clk_1hz & ~clk_1hz_q;

    // Mode FSM plus registered tick strobe; btn_mode always wins over other inputs.
    always_ff @(posedge clk_27Mhz) begin
        if (reset) begin
            clk_1hz_q <= 1'b0;
            state     <= RUN;
            tick_out  <= 1'b0;
        end else begin
            clk_1hz_q <= bus.clk_1hz;
            tick_out  <= sec_inc;
            if (bus.btn_mode) begin
                case (state)
                    RUN:        state <= SET_HR;
                    SET_HR:     state <= SET_MIN;
`ifdef ALARM_EN
                    SET_MIN:    state <= SET_AL_HR;
                    SET_AL_HR:  state <= SET_AL_MIN;
`endif
                    default:    state <= RUN;
                endcase
            end
        end
    end

`ifdef ALARM_EN
    logic      al_hour_inc, al_min_inc, alarm_ring;
    bcd_pair_t al_hour_val, al_min_val;
`endif

    // Increment routing: time runs only in RUN; set modes edit one field with no carry.
    always_comb begin
        sec_inc  = 1'b0;
        min_inc  = 1'b0;
        hour_inc = 1'b0;
        sec_clr  = 1'b0;
`ifdef ALARM_EN
        al_hour_inc = 1'b0;
        al_min_inc  = 1'b0;
`endif
        case (state)
            RUN: begin
                sec_inc  = tick & ~bus.btn_mode;
                min_inc  = sec_carry;
                hour_inc = min_carry;
            end
            SET_HR:  hour_inc = bus.btn_inc & ~bus.btn_mode;
            SET_MIN: begin
                min_inc = bus.btn_inc & ~bus.btn_mode;
`ifndef ALARM_EN
                sec_clr = bus.btn_mode;
`endif
            end
`ifdef ALARM_EN
            SET_AL_HR:  al_hour_inc = bus.btn_inc & ~bus.btn_mode;
            SET_AL_MIN: begin
                al_min_inc = bus.btn_inc & ~bus.btn_mode;
                sec_clr    = bus.btn_mode;
            end
`endif
            default: ;
        endcase
    end

    bcd_mod_counter #(.MAX(MIN_MAX)) u_sec (
        .clk(clk_27Mhz), .reset(reset), .inc(sec_inc), .clr(sec_clr),
        .value(sec_val), .carry(sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk_27Mhz), .reset(reset), .inc(min_inc), .clr(1'b0),
        .value(min_val), .carry(min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk(clk_27Mhz), .reset(reset), .inc(hour_inc), .clr(1'b0),
        .value(hour_val), .carry()
    );

`ifdef ALARM_EN
    bcd_mod_counter #(.MAX(HOUR_MAX)) u_al_hour (
        .clk(clk_27Mhz), .reset(reset), .inc(al_hour_inc), .clr(1'b0),
        .value(al_hour_val), .carry()
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_al_min (
        .clk(clk_27Mhz), .reset(reset), .inc(al_min_inc), .clr(1'b0),
        .value(al_min_val), .carry()
    );

    // Ring is judged one cycle after the tick, once the new hh:mm:00 is visible.
    always_ff @(posedge clk_27Mhz) begin
        if (reset) begin
            alarm_ring <= 1'b0;
        end else if (bus.btn_mode || bus.btn_inc || !bus.alarm_on || min_inc) begin
            alarm_ring <= 1'b0;
        end else if (tick_out && state == RUN && sec_val == BCD_RESET &&
                     hour_val == al_hour_val && min_val == al_min_val) begin
            alarm_ring <= 1'b1;
        end
    end

    assign bus.alarm_ring  = alarm_ring;
    assign bus.al_hour_bcd = al_hour_val;
    assign bus.al_min_bcd  = al_min_val;
`endif

    assign bus.sec_bcd  = sec_val;
    assign bus.min_bcd  = min_val;
    assign bus.hour_bcd = hour_val;
    assign bus.mode     = state;
    assign bus.tick_out = tick_out;

endmodule
